// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM controller: shared prescaler/PWM counter, per-channel
// double-buffered duty/mode, and OFF/STATIC/BLINK/BREATHE effective-duty shaping.
module led_pwm_ctrl #(
    parameter int CHANNELS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 16,
    parameter int BLINK_LOG2 = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [CHANNELS*PWM_BITS-1:0] duty,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic                         load,
    output logic [CHANNELS-1:0]          led_out,
    output logic                         period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PS_W-1:0]       r_pcnt;
    logic [PWM_BITS-1:0]   r_cnt;
    logic [BLINK_LOG2-1:0] r_bcnt;
    logic                  r_blink_phase;

    logic [PWM_BITS-1:0]   r_pend_duty [CHANNELS];
    mode_t                 r_pend_mode [CHANNELS];
    logic                  r_pend_valid;
    logic [PWM_BITS-1:0]   r_act_duty  [CHANNELS];
    mode_t                 r_act_mode  [CHANNELS];

    logic [PWM_BITS-1:0]   r_lvl [CHANNELS];
    dir_t                  r_dir [CHANNELS];

    logic [CHANNELS-1:0]   r_led;
    logic                  r_period_start;

    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_update;
    logic                  w_cycle_start;
    logic [PWM_BITS-1:0]   w_nxt_duty [CHANNELS];
    mode_t                 w_nxt_mode [CHANNELS];
    logic [PWM_BITS-1:0]   w_lvl_nxt  [CHANNELS];
    dir_t                  w_dir_nxt  [CHANNELS];
    logic [PWM_BITS-1:0]   w_eff      [CHANNELS];
    logic [CHANNELS-1:0]   w_pwm_raw;

    function automatic logic [PWM_BITS-1:0] f_eff_duty(
        input mode_t               m,
        input logic [PWM_BITS-1:0] d,
        input logic [PWM_BITS-1:0] lvl,
        input logic                phase
    );
        logic [PWM_BITS-1:0] res;
        res = '0;
        case (m)
            MODE_OFF:     res = '0;
            MODE_STATIC:  res = d;
            MODE_BLINK:   res = phase ? '0 : d;
            MODE_BREATHE: res = lvl;
            default:      res = '0;
        endcase
        return res;
    endfunction

    assign w_tick        = en && (r_pcnt == PS_MAX);
    assign w_boundary    = w_tick && (r_cnt == '1);
    assign w_update      = w_boundary && (load || r_pend_valid);
    // First cycle of a period: counter just wrapped or en just rose.
    assign w_cycle_start = en && (r_cnt == '0) && (r_pcnt == '0);

    // A load coinciding with the boundary bypasses the pending stage.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_nxt_duty[i] = r_act_duty[i];
            w_nxt_mode[i] = r_act_mode[i];
            if (w_update) begin
                if (load) begin
                    w_nxt_duty[i] = duty[i*PWM_BITS +: PWM_BITS];
                    w_nxt_mode[i] = mode_t'(mode[2*i +: 2]);
                end else begin
                    w_nxt_duty[i] = r_pend_duty[i];
                    w_nxt_mode[i] = r_pend_mode[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_lvl_nxt[i] = r_lvl[i];
            w_dir_nxt[i] = r_dir[i];
            if (!en) begin
                w_lvl_nxt[i] = '0;
                w_dir_nxt[i] = DIR_UP;
            end else if (w_boundary) begin
                if ((w_nxt_mode[i] != MODE_BREATHE) || (r_act_mode[i] != MODE_BREATHE)) begin
                    w_lvl_nxt[i] = '0;
                    w_dir_nxt[i] = DIR_UP;
                end else if (w_nxt_duty[i] < r_lvl[i]) begin
                    w_lvl_nxt[i] = w_nxt_duty[i];
                    w_dir_nxt[i] = DIR_DOWN;
                end else if (r_dir[i] == DIR_UP) begin
                    if (r_lvl[i] < w_nxt_duty[i]) begin
                        w_lvl_nxt[i] = r_lvl[i] + PWM_BITS'(1);
                    end else begin
                        w_dir_nxt[i] = DIR_DOWN;
                    end
                end else begin
                    if (r_lvl[i] != '0) begin
                        w_lvl_nxt[i] = r_lvl[i] - PWM_BITS'(1);
                    end else begin
                        w_dir_nxt[i] = DIR_UP;
                    end
                end
            end
        end
    end

    always_comb begin
        w_pwm_raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_eff[i]     = f_eff_duty(r_act_mode[i], r_act_duty[i], r_lvl[i], r_blink_phase);
            w_pwm_raw[i] = (r_cnt < w_eff[i]);
        end
    end

    // Timebase: prescaler, PWM counter, blink counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt        <= '0;
            r_cnt         <= '0;
            r_bcnt        <= '0;
            r_blink_phase <= 1'b0;
        end else if (!en) begin
            r_pcnt        <= '0;
            r_cnt         <= '0;
            r_bcnt        <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + PS_W'(1);
            if (w_tick) begin
                r_cnt <= r_cnt + PWM_BITS'(1);
            end
            if (w_boundary) begin
                r_bcnt <= r_bcnt + BLINK_LOG2'(1);
                if (r_bcnt == '1) begin
                    r_blink_phase <= ~r_blink_phase;
                end
            end
        end
    end

    // Settings: pending capture and active registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_pend_duty[i] <= '0;
                r_pend_mode[i] <= MODE_OFF;
                r_act_duty[i]  <= '0;
                r_act_mode[i]  <= MODE_OFF;
            end
        end else begin
            if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend_valid <= 1'b1;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (load) begin
                    r_pend_duty[i] <= duty[i*PWM_BITS +: PWM_BITS];
                    r_pend_mode[i] <= mode_t'(mode[2*i +: 2]);
                end
                r_act_duty[i] <= w_nxt_duty[i];
                r_act_mode[i] <= w_nxt_mode[i];
            end
        end
    end

    // Breathe level/direction state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_lvl[i] <= '0;
                r_dir[i] <= DIR_UP;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_lvl[i] <= w_lvl_nxt[i];
                r_dir[i] <= w_dir_nxt[i];
            end
        end
    end

    // Output stage: one cycle behind the counter value it reflects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_led          <= en ? w_pwm_raw : '0;
            r_period_start <= w_cycle_start;
        end
    end

    assign led_out      = r_led;
    assign period_start = r_period_start;

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Parametrised multi-channel LED PWM controller that drives the board RGB (or any N-channel) LED pins. It replaces direct pass-through of on/off bits with per-channel duty control, glitch-free double-buffered updates at PWM period boundaries, and four per-channel modes: off, static, blink and breathe. It sits between the SoC register/GPIO interface (duty/mode/load) and the top-level LED pad outputs.

## Interface
- CHANNELS, 3, number of LED channels
- PWM_BITS, 8, width of PWM counter and per-channel duty
- PRESCALE, 16, clk cycles per PWM counter step (>=1)
- BLINK_LOG2, 4, blink half-period = 2^BLINK_LOG2 PWM periods

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global enable; low forces outputs and counters to idle
- duty  in  CHANNELS*PWM_BITS  per-channel duty, channel i at [i*PWM_BITS +: PWM_BITS]
- mode  in  2*CHANNELS  per-channel mode at [2i +: 2]: 00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE
- load  in  1  one-cycle strobe capturing duty/mode into pending registers
- led_out  out  CHANNELS  registered PWM outputs, active-high
- period_start  out  1  registered one-cycle pulse at start of each PWM period

## Operation
- Prescaler pcnt counts 0..PRESCALE-1; tick = en && pcnt==PRESCALE-1. PRESCALE=1: tick every enabled cycle.
- PWM counter cnt (PWM_BITS, unsigned) increments on tick, wraps 2^PWM_BITS-1 -> 0. boundary = tick && cnt==all-ones.
- load captures duty/mode into pending regs and sets pending_valid. On boundary with pending_valid, active regs <= pending, pending_valid <= 0. load in the same cycle as boundary: new inputs go straight to active (not deferred). Multiple loads before a boundary: last wins.
- Effective duty eff[i]: OFF 0; STATIC active duty; BLINK active duty when blink_phase==0, else 0; BREATHE breathe level L[i].
- Compare: pwm_raw[i] = cnt < eff[i] (unsigned). Duty all-ones gives (2^PWM_BITS-1)/2^PWM_BITS high; duty 0 gives constant low.
- Blink: shared counter bcnt (BLINK_LOG2 bits) increments on boundary; blink_phase toggles when bcnt wraps. Phase 0 = lit.
- Breathe per channel: dir state UP/DOWN, level L (PWM_BITS). On each boundary in BREATHE: UP: L<duty -> L+1, else dir<=DOWN; DOWN: L>0 -> L-1, else dir<=UP. Full cycle = 2*duty+2 periods. Entering BREATHE from another mode: L=0, dir=UP. Active duty reduced below L: L clamps to new duty, dir=DOWN, same boundary.
- en low: pcnt, cnt, bcnt, blink_phase, L, dir cleared to reset values; led_out=0, period_start=0; active/pending regs and load capture remain operational. en rising starts a fresh period at cnt=0.
- rst: all state zero; active mode OFF, duty 0, pending_valid 0, dir UP, led_out 0, period_start 0.

## Timing
- led_out[i] <= en && pwm_raw[i]: one cycle after cnt value it reflects.
- period_start registered: high for the one cycle in which cnt==0 is first presented to the compare, aligned with led_out of first slot.
- High time per period = eff[i]*PRESCALE cycles; period = 2^PWM_BITS*PRESCALE cycles.
- load -> effect: new settings visible in led_out on the first period after the next boundary; never mid-period.
- Async rst asserted mid-period: outputs low immediately; after deassert, first period starts at cnt=0 with OFF mode.

## Test plan
- PWM_BITS=4, PRESCALE=2, load duty ch0=4 STATIC, en=1 -> led_out[0] high 8 cycles of every 32, period_start every 32 cycles.
- Duty 0 and 15 STATIC -> ch constantly low; ch high 30 of 32 cycles.
- load duty=12 mid-period (cnt=5) with old duty 4 -> current period keeps 8-cycle high, next period 24-cycle high; no glitch pulse.
- BLINK_LOG2=2, duty=8 BLINK -> 4 periods lit (16 high cycles each), 4 periods dark, repeating.
- BREATHE duty=3 -> per-period high slots 0,1,2,3,3,2,1,0,0,1... (period-level sequence L=0,1,2,3,3,2,1,0,0).
- rst pulse mid-period and en low for 10 cycles -> led_out=0 immediately; after release cnt restarts at 0, period_start on first period, mode OFF until next load.
